// File: rtl/spi_pkg.sv
// spi_pkg -- shared types and helpers for the parameterised SPI master.
//   spi_state_e : transfer FSM states (IDLE, LEAD, XFER, TRAIL, DONE)
//   SPI_MODE0-3 : {cpol,cpha} encodings as reported on the mode output
//   cs_width()  : width of the chip-select index for a given CS count
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } spi_state_e;

    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // A single chip select still gets a 1-bit index so the port never vanishes.
    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen -- SCLK divider and edge counter for the SPI master.
//   clk, rst_n  : system clock, synchronous active-low reset
//   run         : high while the master is in XFER; low clears the counters
//   idle_lvl    : level sclk is parked at whenever run is low
//   sclk        : registered SPI clock
//   lead_edge   : strobe, this cycle's clock edge produces an odd (leading) SCLK edge
//   trail_edge  : strobe, this cycle's clock edge produces an even (trailing) SCLK edge
//   last_edge   : strobe, the edge being produced is edge 2*DATA_W
module spi_sclk_gen #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic idle_lvl,
    output logic sclk,
    output logic lead_edge,
    output logic trail_edge,
    output logic last_edge
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W + 1);

    logic [DIV_W-1:0]  div_q,  div_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic              sclk_q, sclk_d;
    logic              tick;

    // An SCLK edge is produced on the last cycle of every CLK_DIV-cycle slot,
    // so the final edge lands exactly on the last XFER cycle and sclk is back
    // at its idle level when TRAIL begins.
    assign tick = run && (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        sclk_d = sclk_q;
        if (!run) begin
            div_d  = '0;
            edge_d = '0;
            sclk_d = idle_lvl;
        end else if (tick) begin
            div_d  = '0;
            edge_d = edge_q + 1'b1;
            sclk_d = ~sclk_q;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    // edge_q holds the count of edges already produced; the edge in flight is edge_q+1.
    assign lead_edge  = tick && !edge_q[0];
    assign trail_edge = tick &&  edge_q[0];
    assign last_edge  = tick && (edge_q == EDGE_W'(2 * DATA_W - 1));
    assign sclk       = sclk_q;

endmodule

// File: rtl/spi_master_param.sv
// spi_master_param -- parameterised full-duplex SPI master, all four CPOL/CPHA modes.
//   clk, rst_n        : system clock, synchronous active-low reset
//   cpol, cpha        : SPI mode, latched at the tx handshake
//   tx_valid/tx_ready : request handshake; tx_ready is high only in IDLE
//   tx_data, cs_sel   : word to send and chip-select index, latched at handshake
//   rx_data, rx_valid : last received word and its one-cycle update pulse
//   busy, mode        : transfer in progress; {cpol,cpha} of current/last transfer
//   sclk, mosi, miso  : SPI serial pins (sclk/mosi registered)
//   cs_n              : active-low chip selects, registered
// Build option SPI_LSB_FIRST_EN adds input lsb_first (latched at handshake):
// transmit bit 0 first and fill rx from the MSB side so rx_data keeps natural order.
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 1,
    localparam int CS_W   = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic [1:0]        mode,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
`ifdef SPI_LSB_FIRST_EN
    ,
    input  logic              lsb_first
`endif
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    spi_state_e        state_q,    state_d;
    logic [DIV_W-1:0]  cnt_q,      cnt_d;
    logic [DATA_W-1:0] txsh_q,     txsh_d;
    logic [DATA_W-1:0] rxsh_q,     rxsh_d;
    logic [DATA_W-1:0] rx_data_q,  rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              mosi_q,     mosi_d;
    logic [NUM_CS-1:0] cs_n_q,     cs_n_d;
    logic [1:0]        mode_q,     mode_d;
    logic              hs_lsb;

`ifdef SPI_LSB_FIRST_EN
    logic lsb_q, lsb_d;
    assign hs_lsb = lsb_first;
`else
    logic lsb_q;
    assign lsb_q  = 1'b0;
    assign hs_lsb = 1'b0;
`endif

    logic run, idle_lvl, lead_edge, trail_edge, last_edge;
    logic sample, shift;

    function automatic logic out_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_on(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    assign run      = (state_q == XFER);
    // In IDLE sclk follows the live cpol so the line already sits at the new
    // idle level before the handshake; afterwards it follows the latched mode.
    assign idle_lvl = (state_q == IDLE) ? cpol : mode_q[1];

    spi_sclk_gen #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .idle_lvl   (idle_lvl),
        .sclk       (sclk),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge),
        .last_edge  (last_edge)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        mode_d     = mode_q;
`ifdef SPI_LSB_FIRST_EN
        lsb_d      = lsb_q;
`endif
        // CPHA=1 swaps the roles of leading and trailing edges. With CPHA=0 the
        // first bit is already on mosi, so the final trailing edge must not shift.
        sample = mode_q[0] ? trail_edge : lead_edge;
        shift  = mode_q[0] ? lead_edge  : (trail_edge && !last_edge);

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    mode_d  = {cpol, cpha};
                    rxsh_d  = '0;
`ifdef SPI_LSB_FIRST_EN
                    lsb_d   = lsb_first;
`endif
                    // Out-of-range cs_sel matches no line, leaving all deasserted.
                    for (int i = 0; i < NUM_CS; i++) begin
                        cs_n_d[i] = (cs_sel != CS_W'(i));
                    end
                    if (!cpha) begin
                        mosi_d = out_bit(tx_data, hs_lsb);
                        txsh_d = shift_on(tx_data, hs_lsb);
                    end else begin
                        txsh_d = tx_data;
                    end
                end
            end
            LEAD: begin
                if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            XFER: begin
                if (sample) begin
                    rxsh_d = lsb_q ? {miso, rxsh_q[DATA_W-1:1]} : {rxsh_q[DATA_W-2:0], miso};
                end
                if (shift) begin
                    mosi_d = out_bit(txsh_q, lsb_q);
                    txsh_d = shift_on(txsh_q, lsb_q);
                end
                if (last_edge) begin
                    state_d = TRAIL;
                    cnt_d   = '0;
                end
            end
            TRAIL: begin
                if (cnt_q == DIV_W'(CLK_DIV - 1)) begin
                    state_d    = DONE;
                    cs_n_d     = '1;
                    rx_data_d  = rxsh_q;
                    rx_valid_d = 1'b1;
                    mosi_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            mode_q     <= 2'b00;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            mode_q     <= mode_d;
`ifdef SPI_LSB_FIRST_EN
            lsb_q      <= lsb_d;
`endif
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;
    assign mode     = mode_q;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param -- directed self-checking bench for spi_master_param
// (DATA_W=8, CLK_DIV=2, NUM_CS=3). miso is looped back, tied high, or driven
// by a small mode-aware slave that returns 0x96.
module tb_spi_master_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpol, cpha, tx_valid, tx_ready;
    logic [7:0] tx_data, rx_data;
    logic [1:0] cs_sel, mode;
    logic       rx_valid, busy, sclk, mosi, miso;
    logic [2:0] cs_n;
    logic       lsb_first = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    // miso source: 0 loopback, 1 tied high, 2 slave model
    int         miso_mode = 0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0;
    logic [7:0] sl_word = 8'h96;
    logic [7:0] sl_sh = 8'h00;
    logic       sl_miso = 1'b0, sl_prev = 1'b0;

    always #5 clk = ~clk;

    assign miso = (miso_mode == 0) ? mosi : (miso_mode == 1) ? 1'b1 : sl_miso;

    spi_master_param #(
        .DATA_W  (8),
        .CLK_DIV (2),
        .NUM_CS  (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpol      (cpol),
        .cpha      (cpha),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .cs_sel    (cs_sel),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .mode      (mode),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
`ifdef SPI_LSB_FIRST_EN
        ,
        .lsb_first (lsb_first)
`endif
    );

    // Slave: cpha=0 presents bit 7 while deselected and shifts on trailing
    // edges; cpha=1 shifts on leading edges.
    always @(negedge clk) begin
        sl_prev <= sclk;
        if (cs_n == 3'b111) begin
            sl_sh   <= sl_word;
            sl_miso <= s_cpha ? 1'b0 : sl_word[7];
        end else if (sclk != sl_prev) begin
            if (!s_cpha && (sl_prev != s_cpol)) begin
                sl_miso <= sl_sh[6];
                sl_sh   <= sl_sh << 1;
            end
            if (s_cpha && (sl_prev == s_cpol)) begin
                sl_miso <= sl_sh[7];
                sl_sh   <= sl_sh << 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else n_pass++;
    endtask

    // One transfer. Returns latency (cycles after the handshake cycle until
    // rx_valid, -1 on timeout), sclk rising edges seen with a CS low, mosi
    // changes not coincident with a falling sclk, cs_n and mosi right after
    // the handshake. Returns in the DONE cycle.
    task automatic run_xfer(input logic [7:0] d, input logic p, input logic h,
                            input logic [1:0] cs, output int lat, output int rises,
                            output int bad, output logic [2:0] cs_seen, output logic fm);
        logic ps, pm;
        int   k;
        @(negedge clk);
        cpol = p; cpha = h; cs_sel = cs; s_cpol = p; s_cpha = h;
        @(negedge clk);
        chk("sclk_idle_pre", sclk, p);
        chk("tx_ready_pre", tx_ready, 1'b1);
        tx_data = d; tx_valid = 1'b1;
        @(negedge clk);
        // Scramble request inputs while busy; they must be ignored.
        tx_valid = 1'b0; tx_data = ~d; cpol = ~p; cpha = ~h; cs_sel = 2'd0;
        cs_seen = cs_n; fm = mosi;
        ps = sclk; pm = mosi; rises = 0; bad = 0; lat = -1; k = 1;
        while (lat < 0 && k < 200) begin
            if (rx_valid) lat = k;
            else begin
                if (!ps && sclk && cs_n != 3'b111) rises++;
                if (mosi != pm && !(ps && !sclk)) bad++;
                ps = sclk; pm = mosi;
                @(negedge clk);
                k++;
            end
        end
        cpol = p; cpha = h;
    endtask

    int         lat, rises, bad, n, w, npulse, run_len, min_run, edges;
    logic [2:0] cs_seen;
    logic       fm, ps, seen_low;
    int         pc[3];
    logic [7:0] pd[3];

    initial begin
        rst_n = 1'b0; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0;
        tx_data = 8'h00; cs_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_tx_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_cs_n", cs_n, 3'b111);
        chk("rst_mode", mode, 2'b00);
        rst_n = 1'b1;

        // Mode 0 loopback
        miso_mode = 0;
        run_xfer(8'hA5, 1'b0, 1'b0, 2'd0, lat, rises, bad, cs_seen, fm);
        chk("m0_latency", lat, 37);
        chk("m0_rx_data", rx_data, 8'hA5);
        chk("m0_sclk_rises", rises, 8);
        chk("m0_mosi_on_fall", bad, 0);
        chk("m0_cs_n", cs_seen, 3'b110);
        chk("m0_first_mosi", fm, 1'b1);
        chk("m0_busy_done", busy, 1'b1);
        chk("m0_cs_n_done", cs_n, 3'b111);
        chk("m0_mosi_done", mosi, 1'b0);
        @(negedge clk);
        chk("m0_tx_ready_next", tx_ready, 1'b1);
        chk("m0_rx_valid_pulse", rx_valid, 1'b0);
        chk("m0_sclk_idle", sclk, 1'b0);

        // Mode 3, miso tied high
        miso_mode = 1;
        run_xfer(8'h3C, 1'b1, 1'b1, 2'd0, lat, rises, bad, cs_seen, fm);
        chk("m3_latency", lat, 37);
        chk("m3_rx_data", rx_data, 8'hFF);
        chk("m3_mosi_on_fall", bad, 0);
        chk("m3_mode", mode, 2'b11);
        @(negedge clk);
        chk("m3_sclk_idle", sclk, 1'b1);

        // Modes 1 and 2 against the slave model
        miso_mode = 2;
        run_xfer(8'h00, 1'b0, 1'b1, 2'd1, lat, rises, bad, cs_seen, fm);
        chk("m1_rx_data", rx_data, 8'h96);
        chk("m1_mode", mode, 2'b01);
        chk("m1_cs_n", cs_seen, 3'b101);
        run_xfer(8'h00, 1'b1, 1'b0, 2'd0, lat, rises, bad, cs_seen, fm);
        chk("m2_rx_data", rx_data, 8'h96);
        chk("m2_mode", mode, 2'b10);

        // Chip-select decode, including an index past NUM_CS
        miso_mode = 0;
        run_xfer(8'h5A, 1'b0, 1'b0, 2'd2, lat, rises, bad, cs_seen, fm);
        chk("cs2_cs_n", cs_seen, 3'b011);
        chk("cs2_rx_data", rx_data, 8'h5A);
        run_xfer(8'hC3, 1'b0, 1'b0, 2'd3, lat, rises, bad, cs_seen, fm);
        chk("cs3_cs_n", cs_seen, 3'b111);
        chk("cs3_latency", lat, 37);
        chk("cs3_rx_data", rx_data, 8'hC3);

        // Back-to-back with tx_valid held high
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; cs_sel = 2'd0;
        w = 0; npulse = 0; run_len = 0; min_run = 1000; seen_low = 1'b0; n = 0;
        while (npulse < 3 && n < 400) begin
            @(negedge clk);
            n++;
            if (rx_valid) begin
                pc[npulse] = n; pd[npulse] = rx_data; npulse++;
            end
            if (cs_n == 3'b111) run_len++;
            else begin
                if (seen_low && run_len > 0 && run_len < min_run) min_run = run_len;
                seen_low = 1'b1;
                run_len  = 0;
            end
            if (tx_ready) begin
                if (w < 3) begin
                    tx_data = 8'(w + 1); tx_valid = 1'b1; w++;
                end else tx_valid = 1'b0;
            end
        end
        tx_valid = 1'b0;
        chk("b2b_pulses", npulse, 3);
        if (npulse == 3) begin
            chk("b2b_word0", pd[0], 8'h01);
            chk("b2b_word1", pd[1], 8'h02);
            chk("b2b_word2", pd[2], 8'h03);
            chk("b2b_gap01", pc[1] - pc[0], 38);
            chk("b2b_gap12", pc[2] - pc[1], 38);
        end
        chk("b2b_cs_high_min", min_run, 2);

        // Reset after the 7th SCLK edge of a transfer
        @(negedge clk);
        @(negedge clk);
        tx_data = 8'hFF; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        edges = 0; n = 0; ps = sclk;
        while (edges < 7 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk != ps) edges++;
            ps = sclk;
        end
        chk("rst_edge7_reached", edges, 7);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_cs_n", cs_n, 3'b111);
        chk("mid_rst_sclk", sclk, 1'b0);
        chk("mid_rst_tx_ready", tx_ready, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rx_valid", rx_valid, 1'b0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        rst_n = 1'b1;
        npulse = 0;
        repeat (45) begin
            @(negedge clk);
            if (rx_valid) npulse++;
        end
        chk("mid_rst_no_rx_valid", npulse, 0);

`ifdef SPI_LSB_FIRST_EN
        lsb_first = 1'b1;
        run_xfer(8'h01, 1'b0, 1'b0, 2'd0, lat, rises, bad, cs_seen, fm);
        chk("lsb_first_mosi", fm, 1'b1);
        chk("lsb_rx_data", rx_data, 8'h01);
        run_xfer(8'h2C, 1'b0, 1'b1, 2'd0, lat, rises, bad, cs_seen, fm);
        chk("lsb_m1_rx_data", rx_data, 8'h2C);
        lsb_first = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
